// File: rtl/ieee_mul_arbiter_pkg.sv
// rtl/ieee_mul_arbiter_pkg.sv - shared types and FP32 field constants for the multiplier arbiter
package ieee_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  // A zero exponent field means zero or denormal; the core cannot handle either
  function automatic logic exp_is_zero(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == '0);
  endfunction

endpackage

// File: rtl/ieee_mul.sv
// rtl/ieee_mul.sv - combinational single-precision multiplier core for normalised operands
module ieee_mul
  import ieee_mul_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic [MANT_W:0]     ma;
  logic [MANT_W:0]     mb;
  logic [2*MANT_W+1:0] prod;
  logic                norm;
  logic [MANT_W-1:0]   mant;
  logic                guard;
  logic                sticky;
  logic                rnd;
  logic [7:0]          exp_r;
  logic [30:0]         mag;

  // Multiply significands, normalise by at most one place, round to nearest even.
  // The exponent is computed modulo 256: adding 129 is the same as subtracting the bias.
  always_comb begin
    ma   = {1'b1, a[MANT_W-1:0]};
    mb   = {1'b1, b[MANT_W-1:0]};
    prod = ma * mb;
    norm = prod[2*MANT_W+1];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd   = guard & (sticky | mant[0]);
    exp_r = a[EXP_MSB:EXP_LSB] + b[EXP_MSB:EXP_LSB] + 8'd129 + {7'b0, norm};
    mag   = {exp_r, mant} + {30'b0, rnd};
    p     = {a[SIGN_BIT] ^ b[SIGN_BIT], mag};
  end

endmodule

// File: rtl/ieee_mul_arbiter_rr_arbiter.sv
// rtl/ieee_mul_arbiter_rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

  int j;

  // Walk the request vector from ptr upward with wrap; the first hit wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/ieee_mul_arbiter.sv
// rtl/ieee_mul_arbiter.sv - round-robin sharing of one FP32 multiplier between N_REQ requesters
module ieee_mul_arbiter
  import ieee_mul_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int TAG_W = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [32*N_REQ-1:0]    req_a,
  input  logic [32*N_REQ-1:0]    req_b,
  input  logic [TAG_W*N_REQ-1:0] req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy
);

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [TAG_W-1:0]  op_tag;
  logic [ID_W-1:0]   op_id;
  logic [31:0]       core_p;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  ieee_mul u_core (
    .a (op_a),
    .b (op_b),
    .p (core_p)
  );

  // In IDLE the granted requester sees ready, so any grant is also a handshake
  assign accept = (state == IDLE) && grant_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> CALC on accept, CALC always one cycle, RESP waits for the consumer
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (grant_valid) next_state = CALC;
      CALC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; ready is masked while reset is held so nothing looks accepted
  always_comb begin
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    req_ready = '0;
    if (accept && rst_n) req_ready = N_REQ'(1) << grant_idx;
  end

  // Operand capture and pointer advance on accept; product capture with zero override in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_tag   <= '0;
      op_id    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_tag  <= '0;
    end else begin
      if (accept) begin
        op_a   <= req_a[32*int'(grant_idx) +: 32];
        op_b   <= req_b[32*int'(grant_idx) +: 32];
        op_tag <= req_tag[TAG_W*int'(grant_idx) +: TAG_W];
        op_id  <= grant_idx;
        rr_ptr <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == CALC) begin
        if (exp_is_zero(op_a) || exp_is_zero(op_b))
          rsp_data <= {op_a[SIGN_BIT] ^ op_b[SIGN_BIT], 31'b0};
        else
          rsp_data <= core_p;
        rsp_id  <= op_id;
        rsp_tag <= op_tag;
      end
    end
  end

endmodule

// File: tb/tb_ieee_mul_arbiter.sv
// tb/tb_ieee_mul_arbiter.sv - self-checking bench for ieee_mul_arbiter
module tb_ieee_mul_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [TW*N-1:0] req_tag;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  ieee_mul_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    logic [10:0] e;
    e = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  // Reference: exact product in double precision, then round-to-nearest-even down to single
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [7:0]  e8;
    logic        rnd;
    logic [30:0] mag;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
    d   = $realtobits(to_real(a) * to_real(b));
    e8  = 8'(d[62:52] - 11'd896);
    rnd = d[28] & ((|d[27:0]) | d[29]);
    mag = {e8, d[51:29]} + 31'(rnd);
    return {d[63], mag};
  endfunction

  function automatic int expect_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    e = 8'($urandom_range(64, 189));
    if ($urandom_range(0, 7) == 0) e = 8'd0;
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    req_a[i*32 +: 32]   = a;
    req_b[i*32 +: 32]   = b;
    req_tag[i*TW +: TW] = tag;
    req_valid[i]        = 1'b1;
  endtask

  // Starts at a falling edge with the DUT idle and rsp_ready high; ends at a falling edge, idle again
  task automatic run_one(input string nm, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp_data);
    set_req(i, a, b, tag);
    #1;
    chk($sformatf("%s ready", nm), 32'(req_ready), 32'(1 << i));
    model_ptr = (i + 1) % N;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    chk($sformatf("%s calc flags", nm), {29'b0, busy, rsp_valid, |req_ready}, 32'b100);
    @(negedge clk);
    chk($sformatf("%s rsp_valid", nm), 32'(rsp_valid), 32'd1);
    chk($sformatf("%s rsp_data", nm), rsp_data, exp_data);
    chk($sformatf("%s rsp_id", nm), 32'(rsp_id), 32'(i));
    chk($sformatf("%s rsp_tag", nm), 32'(rsp_tag), 32'(tag));
    @(negedge clk);
    chk($sformatf("%s back idle", nm), {30'b0, busy, rsp_valid}, 32'b0);
  endtask

  vec_t        tbl[6];
  logic [31:0] pa[N];
  logic [31:0] pb[N];
  int          g;

  initial begin
    tbl[0] = '{0, 32'h4000_0000, 32'h4040_0000, 4'h5, 32'h40C0_0000};
    tbl[1] = '{2, 32'h3FC0_0000, 32'hC000_0000, 4'hA, 32'hC040_0000};
    tbl[2] = '{2, 32'h8000_0000, 32'h4040_0000, 4'h3, 32'h8000_0000};
    tbl[3] = '{1, 32'h3F80_0000, 32'h3F80_0000, 4'hF, 32'h3F80_0000};
    tbl[4] = '{3, 32'h4000_0000, 32'h0000_0000, 4'h1, 32'h0000_0000};
    tbl[5] = '{1, 32'hC000_0000, 32'h0040_0000, 4'h7, 32'h8000_0000};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'b0101;
    #1;
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset outputs", {rsp_data}, 32'd0);
    chk("reset id/tag/flags", {24'b0, rsp_id, rsp_tag, busy, rsp_valid}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle quiet", {25'b0, req_ready, busy, rsp_valid, 1'b0}, 32'd0);
    end

    for (int t = 0; t < 6; t++)
      run_one($sformatf("vec%0d", t), tbl[t].id, tbl[t].a, tbl[t].b, tbl[t].tag, tbl[t].exp_data);

    for (int r = 0; r < 40; r++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rt;
      int          ri;
      ra = rand_operand(); rb = rand_operand(); rt = 4'($urandom); ri = $urandom_range(0, N-1);
      run_one($sformatf("rand%0d", r), ri, ra, rb, rt, model_mul(ra, rb));
    end

    // Plain reset before the fairness run so the pointer starts at 0
    rst_n = 1'b0; model_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      pa[i] = rand_operand(); pb[i] = rand_operand();
      set_req(i, pa[i], pb[i], 4'(i + 8));
    end
    for (int s = 0; s < 5; s++) begin
      #1;
      g = expect_grant(req_valid);
      chk($sformatf("rr%0d grant", s), 32'(req_ready), 32'(1 << g));
      chk($sformatf("rr%0d order", s), 32'(g), 32'(s % N));
      model_ptr = (g + 1) % N;
      @(negedge clk);
      chk($sformatf("rr%0d calc", s), {30'b0, rsp_valid, |req_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("rr%0d valid", s), 32'(rsp_valid), 32'd1);
      chk($sformatf("rr%0d data", s), rsp_data, model_mul(pa[g], pb[g]));
      chk($sformatf("rr%0d id", s), 32'(rsp_id), 32'(g));
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

    // Back-pressure: response held for 5 cycles, no grant meanwhile
    pa[1] = rand_operand(); pb[1] = rand_operand();
    pa[2] = rand_operand(); pb[2] = rand_operand();
    set_req(1, pa[1], pb[1], 4'h9);
    set_req(2, pa[2], pb[2], 4'h6);
    rsp_ready = 1'b0;
    #1;
    g = expect_grant(req_valid);
    chk("stall grant", 32'(req_ready), 32'(1 << g));
    model_ptr = (g + 1) % N;
    @(negedge clk);
    req_valid[g] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d data", c), rsp_data, model_mul(pa[g], pb[g]));
      chk($sformatf("stall%0d id/tag", c), {26'b0, rsp_id, rsp_tag}, {26'b0, 2'(g), (g == 1) ? 4'h9 : 4'h6});
      chk($sformatf("stall%0d ready", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall release valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("stall done", 32'(rsp_valid), 32'd0);
    g = expect_grant(req_valid);
    chk("post stall grant", 32'(req_ready), 32'(1 << g));
    model_ptr = (g + 1) % N;
    @(negedge clk);
    req_valid[g] = 1'b0;
    @(negedge clk);
    chk("post stall data", rsp_data, model_mul(pa[g], pb[g]));
    @(negedge clk);

    // Reset during CALC discards the operation and rewinds the pointer
    pa[1] = 32'h4000_0000; pb[1] = 32'h4080_0000;
    pa[3] = 32'h3F80_0000; pb[3] = 32'hBF80_0000;
    set_req(1, pa[1], pb[1], 4'h2);
    set_req(3, pa[3], pb[3], 4'h4);
    #1;
    g = expect_grant(req_valid);
    chk("pre-reset grant", 32'(req_ready), 32'(1 << g));
    @(negedge clk);
    rst_n = 1'b0;
    model_ptr = 0;
    #1;
    chk("mid reset flags", {29'b0, busy, rsp_valid, |req_ready}, 32'd0);
    chk("mid reset data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after reset grant", 32'(req_ready), 32'(1 << expect_grant(req_valid)));
    model_ptr = 2;
    @(negedge clk);
    req_valid = '0;
    chk("after reset calc", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("after reset valid", 32'(rsp_valid), 32'd1);
    chk("after reset data", rsp_data, 32'h4100_0000);
    chk("after reset id", 32'(rsp_id), 32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ieee_mul_arbiter.md
Name: ieee_mul_arbiter

Overview:
- Shares one single-precision IEEE-754 multiplier core (ieee_mul, combinational, 32-bit operands) between N_REQ requesters.
- Round-robin arbitration and a valid/ready request handshake per requester.
- Operands are registered into the core, the product is registered out, and the result is returned on a single response channel tagged with requester id and user tag.
- Sits between the processing lanes and the shared multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TAG_W, 4, width of the user tag carried with each request.
- ID_W, $clog2(N_REQ), width of the requester index (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  in  32*N_REQ  multiplicand; slice i belongs to requester i.
- req_b  in  32*N_REQ  multiplier; slice i belongs to requester i.
- req_tag  in  TAG_W*N_REQ  user tag; slice i belongs to requester i.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  IEEE-754 product.
- rsp_id  out  ID_W  index of the requester served.
- rsp_tag  out  TAG_W  tag echoed from the accepted request.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, busy=0.
  - rsp_data=0, rsp_id=0, rsp_tag=0, all operand/tag registers zero.
- FSM states:
  - IDLE: grant = first i with req_valid[i], searching from rr_ptr upward, wrapping modulo N_REQ. req_ready is combinational and high only for the granted bit. On handshake (req_valid[g]&&req_ready[g]): latch a, b, tag, and g into operand registers; rr_ptr <= (g+1) mod N_REQ; go to CALC. If no request is valid, stay in IDLE and leave rr_ptr unchanged.
  - CALC: one cycle. Capture the core output into rsp_data and go to RESP.
  - RESP: rsp_valid=1. rsp_data, rsp_id and rsp_tag are held stable until rsp_ready. On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted in cycle t, rsp_valid high in cycle t+2. Minimum issue interval is 3 cycles. No new request is accepted while not in IDLE (req_ready=0 in CALC/RESP).
- Zero handling: the core assumes normalised inputs, so the controller overrides its output. If a[30:23]==0 or b[30:23]==0, rsp_data = {a[31]^b[31], 31'b0}, i.e. signed zero.
- No other special-value handling (Inf/NaN/denormal); those results are whatever the core produces.
- Requests must hold valid and payload stable until accepted. A requester dropping valid before grant is not an error; arbitration re-evaluates each IDLE cycle.
- Simultaneous requests: strict round-robin. No requester waits more than N_REQ-1 grants.
- rsp_ready already high when RESP is entered: the response completes in that same cycle (rsp_valid high for exactly one cycle).
- Reset asserted mid-operation: the operation is discarded, no response is emitted, and rr_ptr returns to 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CALC, RESP).
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23.
- One sub-module: rr_arbiter, a combinational round-robin grant from a request vector and rr_ptr.
- The multiplier core is instantiated unchanged inside ieee_mul_arbiter.

Test Plan:
- Reset release, no requests for 10 cycles -> req_ready=0, rsp_valid=0, busy=0 throughout.
- Req0: a=0x40000000, b=0x40400000, tag=0x5 -> rsp_valid at t+2, rsp_data=0x40C00000, rsp_id=0, rsp_tag=0x5.
- Req2: a=0x3FC00000, b=0xC0000000 -> rsp_data=0xC0400000; repeat with a=0x80000000, b=0x40400000 -> rsp_data=0x80000000.
- All four requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles; rr_ptr wraps from 3 to 0.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and payload stable for 5 cycles; req_ready stays 0; next grant only after the handshake.
- rst_n pulsed low during CALC -> no response emitted; the next grant goes to the lowest valid index starting from 0.
